imem_fetch_router: RTL and testbench
====================================

# imem_fetch_router

Parametrised instruction-fetch router between the fetch stage and NUM_REGIONS instruction sources (ITCM, DTCM, IAHB, …). It is the successor to the fixed three-way instruction memory controller.

- Decodes each fetch address against per-region base/size windows, each window gated by a runtime enable.
- Issues the request to exactly one region with a request/grant handshake.
- Tracks up to MAX_OUTSTANDING in-flight fetches in a tag FIFO and returns responses to fetch strictly in order.
- Supports pipeline flush, with silent discard of stale responses.

## Interface
- ADDR_WIDTH, 32, fetch address width
- INSTR_WIDTH, 32, instruction width
- NUM_REGIONS, 3, number of sources; index NUM_REGIONS-1 is the default (bus) region
- MAX_OUTSTANDING, 2, tag FIFO depth (1..8)
- REGION_BASE, {NUM_REGIONS{32'h0}}, packed base addresses, region i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- REGION_SIZE, {NUM_REGIONS{32'h0}}, packed window sizes in bytes; ignored for the default region
- Tag width TW = max(1, clog2(NUM_REGIONS))

Ports:
- cpu_clk  in  1  CPU clock; all logic on its rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_WIDTH  fetch address, word aligned
- fetch_gnt  out  1  request accepted this cycle
- flush  in  1  redirect; kill all in-flight fetches
- instr_read_data  out  INSTR_WIDTH  returned instruction
- instr_read_data_valid  out  1  instruction valid, one-cycle pulse
- instr_region  out  TW  region that supplied instr_read_data
- region_en  in  NUM_REGIONS  runtime window enable per region; bit NUM_REGIONS-1 ignored
- region_block  in  NUM_REGIONS  region busy (e.g. ITCM auto-load); blocks both grant and response
- region_req  out  NUM_REGIONS  one-hot request
- region_addr  out  ADDR_WIDTH  shared request address (= fetch_addr)
- region_gnt  in  NUM_REGIONS  region accepts request
- region_rdata  in  NUM_REGIONS*INSTR_WIDTH  packed read data
- region_rvalid  in  NUM_REGIONS  read data valid
- resp_err  out  1  sticky: rvalid seen from a region that is not at the FIFO head

## Operation
- **Address decode (combinational).** sel is the lowest i < NUM_REGIONS-1 with region_en[i] and REGION_BASE_i <= fetch_addr < REGION_BASE_i + REGION_SIZE_i. If no window matches, sel = NUM_REGIONS-1.
  - The compare uses ADDR_WIDTH+1 bits so that base+size does not wrap.
- **Request.** region_req[sel] = fetch_req & !flush & !full & !region_block[sel]. All other region_req bits are 0. fetch_gnt = region_req[sel] & region_gnt[sel].
- **Tag FIFO.** Circular buffer of MAX_OUTSTANDING TW-bit entries.
  - Each entry carries a discard bit.
  - Push on fetch_gnt, pop on head response.
  - count is clog2(MAX_OUTSTANDING)+1 bits.
  - full = (count == MAX_OUTSTANDING). Pointers wrap modulo MAX_OUTSTANDING.
  - Push and pop in the same cycle leave count unchanged.
- **Response.** With h = head tag and non-empty FIFO, a head response is region_rvalid[h] & !region_block[h].
  - Always pops the head entry.
  - Registers region_rdata[h] into instr_read_data, h into instr_region, and sets instr_read_data_valid — unless the head entry's discard bit is set, in which case the response is dropped and valid stays 0.
- **Error handling.** region_rvalid[j] with j != h, or any rvalid while the FIFO is empty, is ignored and sets resp_err. resp_err clears only on reset.
- **Flush.** On flush, every entry present at the end of the cycle gets its discard bit set, including an entry popped this cycle; that response is dropped.
  - No push occurs during a flush cycle.
  - Entries pushed after the flush cycle are not discarded.
- **Reset.** Reset mid-operation empties the FIFO. Responses arriving after reset deassertion are treated as spurious (resp_err).

## Timing
- Reset values:
  - fetch_gnt 0, region_req 0 (fetch_req low)
  - instr_read_data 0, instr_read_data_valid 0, instr_region 0, resp_err 0
  - FIFO empty, pointers 0
- Request path is combinational: fetch_addr → region_req/region_addr → fetch_gnt in the same cycle.
- Response latency: region_rvalid in cycle N → instr_read_data_valid in cycle N+1. Data holds until the next valid response.
- Throughput: one grant and one response per cycle. A full FIFO blocks grant even if a pop occurs that cycle.
- Max in-flight fetches is MAX_OUTSTANDING. Any number of regions may be in flight, provided the regions respond in issue order.

## Test plan
- **In-order mixed regions.** REGION_BASE={AHB,0x2000_0000,0x0}, sizes 64 KiB. Issue fetches 0x0000_0010 then 0x2000_0004; rvalid from ITCM (region 0, data 0x0000_0013), then DTCM (region 1, data 0x00A0_0093).
  - Required: two valid pulses, each one cycle after its rvalid, with instr_region 0 then 1 and the matching data.
- **Default decode and disabled window.** region_en[1]=0, fetch 0x2000_0004.
  - Required: region_req = 3'b100, with response returned from region 2.
- **Back-pressure on full FIFO.** MAX_OUTSTANDING=2, three back-to-back grantable requests.
  - Required: third fetch_gnt=0 until the cycle after the first response pops. Pointers wrap, and four total fetches return in order.
- **Flush with two in flight.** Assert flush for one cycle, then issue a new fetch to 0x0000_0100.
  - Required: the two stale rvalids produce no instr_read_data_valid; the new fetch returns normally. Flush coincident with a head rvalid also drops that response.
- **Block and spurious response.**
  - region_block[0]=1 suppresses region_req[0] and holds the head response until release.
  - rvalid from region 1 while the head is region 0 sets resp_err=1 and leaves the FIFO unchanged.
- **Reset mid-operation.** Assert cpu_rst with two entries in flight.
  - Required: all outputs read their reset values immediately (asynchronous). A later rvalid sets only resp_err.

Source files
------------

// File: rtl/imem_fetch_router.sv
// -----------------------------------------------------------------------------
// imem_fetch_router
//
// Routes instruction fetches from the fetch stage to one of NUM_REGIONS
// instruction sources and returns their read data to fetch in issue order.
//
// Each fetch address is decoded against per-region base/size windows. Every
// window is gated by a runtime enable. An address that matches no window goes
// to the last region, which is the default (bus) region. Each request is
// issued to exactly one region through a request/grant handshake. Granted
// fetches are tracked in a tag FIFO of up to MAX_OUTSTANDING entries. Only the
// region at the FIFO head may complete a fetch. A flush marks every in-flight
// entry as discard, so stale responses are consumed silently.
//
// Ports:
//   cpu_clk, cpu_rst         clock; asynchronous active-high reset
//   fetch_req/fetch_addr     fetch request and word-aligned address
//   fetch_gnt                request accepted this cycle
//   flush                    kill all in-flight fetches
//   instr_read_data(_valid)  returned instruction and its one-cycle strobe
//   instr_region             region that supplied instr_read_data
//   region_en                runtime window enable (default-region bit ignored)
//   region_block             region busy; blocks both grant and response
//   region_req/region_addr   one-hot request and shared address
//   region_gnt               region accepts request
//   region_rdata/rvalid      packed read data and valid strobes
//   resp_err                 sticky: response from a region not at FIFO head
// -----------------------------------------------------------------------------
module imem_fetch_router #(
  parameter int ADDR_WIDTH      = 32,
  parameter int INSTR_WIDTH     = 32,
  parameter int NUM_REGIONS     = 3,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_SIZE = '0,
  localparam int TW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                               cpu_clk,
  input  logic                               cpu_rst,
  input  logic                               fetch_req,
  input  logic [ADDR_WIDTH-1:0]              fetch_addr,
  output logic                               fetch_gnt,
  input  logic                               flush,
  output logic [INSTR_WIDTH-1:0]             instr_read_data,
  output logic                               instr_read_data_valid,
  output logic [TW-1:0]                      instr_region,
  input  logic [NUM_REGIONS-1:0]             region_en,
  input  logic [NUM_REGIONS-1:0]             region_block,
  output logic [NUM_REGIONS-1:0]             region_req,
  output logic [ADDR_WIDTH-1:0]              region_addr,
  input  logic [NUM_REGIONS-1:0]             region_gnt,
  input  logic [NUM_REGIONS*INSTR_WIDTH-1:0] region_rdata,
  input  logic [NUM_REGIONS-1:0]             region_rvalid,
  output logic                               resp_err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // The window compare is one bit wider than the address, so that a window
  // ending at the top of the address space does not wrap to zero.
  logic [NUM_REGIONS-1:0] win_hit;

  for (genvar gi = 0; gi < NUM_REGIONS - 1; gi++) begin : g_win
    localparam logic [ADDR_WIDTH:0] WIN_LO =
      {1'b0, REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]};
    localparam logic [ADDR_WIDTH:0] WIN_HI =
      WIN_LO + {1'b0, REGION_SIZE[gi*ADDR_WIDTH +: ADDR_WIDTH]};
    assign win_hit[gi] = region_en[gi]
                       && ({1'b0, fetch_addr} >= WIN_LO)
                       && ({1'b0, fetch_addr} <  WIN_HI);
  end
  // The default region catches every address that no window claims.
  assign win_hit[NUM_REGIONS-1] = 1'b1;

  logic [TW-1:0] sel;

  // NOTE: every variable written in always_comb gets a default first, so that
  // no path leaves it unassigned and infers a latch.
  always_comb begin
    sel = TW'(NUM_REGIONS - 1);
    // Scan from the top down, so that the lowest matching window wins.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (win_hit[i]) sel = TW'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO state
  // ---------------------------------------------------------------------------
  logic [TW-1:0]              tag_mem [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] discard_q, discard_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;

  logic full, empty;
  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Request path (combinational)
  // ---------------------------------------------------------------------------
  logic [NUM_REGIONS-1:0] sel_oh;
  logic                   req_ok;
  logic                   push;

  assign sel_oh      = NUM_REGIONS'(1) << sel;
  assign req_ok      = fetch_req && !flush && !full && !(|(region_block & sel_oh));
  assign region_req  = req_ok ? sel_oh : '0;
  assign region_addr = fetch_addr;
  assign fetch_gnt   = req_ok && (|(region_gnt & sel_oh));
  assign push        = fetch_gnt;

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  logic [TW-1:0]          head_tag;
  logic [NUM_REGIONS-1:0] head_oh;
  logic                   pop;
  logic                   spurious;
  logic                   deliver;
  logic [INSTR_WIDTH-1:0] head_data;

  assign head_tag = tag_mem[rd_ptr_q];
  assign head_oh  = NUM_REGIONS'(1) << head_tag;

  // A head region that raises rvalid while blocked is not an error. The
  // response is held until the block is released.
  assign pop      = !empty && (|(region_rvalid & head_oh & ~region_block));
  assign spurious = empty ? (|region_rvalid) : (|(region_rvalid & ~head_oh));

  // The entry popped during a flush cycle counts as in flight, so its
  // response is dropped as well.
  assign deliver  = pop && !discard_q[rd_ptr_q] && !flush;

  always_comb begin
    head_data = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (head_tag == TW'(i)) head_data = region_rdata[i*INSTR_WIDTH +: INSTR_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q;
    discard_d = discard_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) discard_d[wr_ptr_q] = 1'b0;
    // No push happens in a flush cycle. Marking every slot, including empty
    // ones, is therefore safe: the next push into a slot clears its bit.
    if (flush) discard_d = '1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so that every
  // flop samples the values from before the edge, whatever the statement order.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      discard_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      discard_q <= discard_d;
    end
  end

  // NOTE: the tag storage is deliberately left without reset. An entry is only
  // read after a push has written it, and count_q (which is reset) decides
  // whether it is live.
  always_ff @(posedge cpu_clk) begin
    if (push) tag_mem[wr_ptr_q] <= sel;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [INSTR_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic [TW-1:0]          region_q, region_d;
  logic                   err_q, err_d;

  always_comb begin
    rvalid_d = deliver;
    rdata_d  = deliver ? head_data : rdata_q;
    region_d = deliver ? head_tag  : region_q;
    err_d    = err_q | spurious;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      region_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      region_q <= region_d;
      err_q    <= err_d;
    end
  end

  assign instr_read_data       = rdata_q;
  assign instr_read_data_valid = rvalid_q;
  assign instr_region          = region_q;
  assign resp_err              = err_q;

endmodule

// File: tb/tb_imem_fetch_router.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_router
//
// Self-checking bench for imem_fetch_router with three regions: ITCM at 0x0,
// DTCM at 0x2000_0000 (64 KiB windows each) and a default AHB region.
// Inputs change on the falling clock edge. Outputs are compared 1 time unit
// later, so that the comparisons fall between the rising edges.
// -----------------------------------------------------------------------------
module tb_imem_fetch_router;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int NR = 3;
  localparam int MO = 2;
  localparam int TW = 2;

  logic                cpu_clk;
  logic                cpu_rst;
  logic                fetch_req;
  logic [AW-1:0]       fetch_addr;
  logic                fetch_gnt;
  logic                flush;
  logic [IW-1:0]       instr_read_data;
  logic                instr_read_data_valid;
  logic [TW-1:0]       instr_region;
  logic [NR-1:0]       region_en;
  logic [NR-1:0]       region_block;
  logic [NR-1:0]       region_req;
  logic [AW-1:0]       region_addr;
  logic [NR-1:0]       region_gnt;
  logic [NR*IW-1:0]    region_rdata;
  logic [NR-1:0]       region_rvalid;
  logic                resp_err;

  int checks = 0;
  int errors = 0;

  imem_fetch_router #(
    .ADDR_WIDTH      (AW),
    .INSTR_WIDTH     (IW),
    .NUM_REGIONS     (NR),
    .MAX_OUTSTANDING (MO),
    .REGION_BASE     ({32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
    .REGION_SIZE     ({32'h0000_0000, 32'h0001_0000, 32'h0001_0000})
  ) dut (
    .cpu_clk               (cpu_clk),
    .cpu_rst               (cpu_rst),
    .fetch_req             (fetch_req),
    .fetch_addr            (fetch_addr),
    .fetch_gnt             (fetch_gnt),
    .flush                 (flush),
    .instr_read_data       (instr_read_data),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_region          (instr_region),
    .region_en             (region_en),
    .region_block          (region_block),
    .region_req            (region_req),
    .region_addr           (region_addr),
    .region_gnt            (region_gnt),
    .region_rdata          (region_rdata),
    .region_rvalid         (region_rvalid),
    .resp_err              (resp_err)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge, where inputs are driven.
  task automatic nxt();
    @(negedge cpu_clk);
  endtask

  task automatic rv(input logic [NR-1:0] mask, input int idx, input logic [IW-1:0] d);
    region_rdata[idx*IW +: IW] = d;
    region_rvalid = mask;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
  endtask

  task automatic resp_chk(input string name, input logic v, input logic [IW-1:0] d,
                          input logic [TW-1:0] r);
    check({name, ".valid"}, 64'(instr_read_data_valid), 64'(v));
    check({name, ".data"},  64'(instr_read_data), 64'(d));
    check({name, ".region"}, 64'(instr_region), 64'(r));
  endtask

  typedef struct {
    logic [NR-1:0] en;
    logic [AW-1:0] addr;
    logic [NR-1:0] blk;
    logic [NR-1:0] gnt;
    logic          req;
    logic [NR-1:0] exp_req;
    logic          exp_gnt;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Decode and request vectors, with the FIFO empty and no flush.
    vecs[0]  = '{3'b011, 32'h0000_0010, 3'b000, 3'b111, 1'b1, 3'b001, 1'b1};
    vecs[1]  = '{3'b011, 32'h2000_0004, 3'b000, 3'b111, 1'b1, 3'b010, 1'b1};
    vecs[2]  = '{3'b001, 32'h2000_0004, 3'b000, 3'b111, 1'b1, 3'b100, 1'b1};
    vecs[3]  = '{3'b011, 32'h0000_FFFC, 3'b000, 3'b111, 1'b1, 3'b001, 1'b1};
    vecs[4]  = '{3'b011, 32'h0001_0000, 3'b000, 3'b111, 1'b1, 3'b100, 1'b1};
    vecs[5]  = '{3'b011, 32'h2000_FFFC, 3'b000, 3'b111, 1'b1, 3'b010, 1'b1};
    vecs[6]  = '{3'b011, 32'h2001_0000, 3'b000, 3'b111, 1'b1, 3'b100, 1'b1};
    vecs[7]  = '{3'b000, 32'h0000_0010, 3'b000, 3'b111, 1'b1, 3'b100, 1'b1};
    vecs[8]  = '{3'b011, 32'h0000_0010, 3'b001, 3'b111, 1'b1, 3'b000, 1'b0};
    vecs[9]  = '{3'b011, 32'h0000_0010, 3'b000, 3'b110, 1'b1, 3'b001, 1'b0};
    vecs[10] = '{3'b011, 32'h0000_0010, 3'b000, 3'b111, 1'b0, 3'b000, 1'b0};
    vecs[11] = '{3'b011, 32'hFFFF_FFFC, 3'b000, 3'b111, 1'b1, 3'b100, 1'b1};

    cpu_rst       = 1'b1;
    fetch_req     = 1'b0;
    fetch_addr    = '0;
    flush         = 1'b0;
    region_en     = 3'b011;
    region_block  = '0;
    region_gnt    = 3'b111;
    region_rdata  = '0;
    region_rvalid = '0;

    // Reset values
    #12;
    resp_chk("reset", 1'b0, 32'h0, 2'd0);
    check("reset.resp_err", 64'(resp_err), 64'd0);
    check("reset.fetch_gnt", 64'(fetch_gnt), 64'd0);
    check("reset.region_req", 64'(region_req), 64'd0);
    nxt();
    cpu_rst = 1'b0;

    // Table-driven decode vectors. fetch_req is dropped before the next rising
    // edge, so nothing is pushed.
    for (int i = 0; i < 12; i++) begin
      nxt();
      region_en    = vecs[i].en;
      fetch_addr   = vecs[i].addr;
      region_block = vecs[i].blk;
      region_gnt   = vecs[i].gnt;
      fetch_req    = vecs[i].req;
      #1;
      check($sformatf("vec%0d.region_req", i), 64'(region_req), 64'(vecs[i].exp_req));
      check($sformatf("vec%0d.fetch_gnt", i), 64'(fetch_gnt), 64'(vecs[i].exp_gnt));
      check($sformatf("vec%0d.region_addr", i), 64'(region_addr), 64'(vecs[i].addr));
      fetch_req = 1'b0;
    end
    region_en = 3'b011; region_block = '0; region_gnt = 3'b111;

    // In-order mixed regions
    nxt(); fetch(32'h0000_0010); #1;
    check("mix.gnt0", 64'(fetch_gnt), 64'd1);
    check("mix.req0", 64'(region_req), 64'b001);
    nxt(); fetch(32'h2000_0004); #1;
    check("mix.gnt1", 64'(fetch_gnt), 64'd1);
    check("mix.req1", 64'(region_req), 64'b010);
    nxt(); fetch_req = 1'b0; rv(3'b001, 0, 32'h0000_0013); #1;
    check("mix.novalid", 64'(instr_read_data_valid), 64'd0);
    nxt(); rv(3'b010, 1, 32'h00A0_0093); #1;
    resp_chk("mix.r0", 1'b1, 32'h0000_0013, 2'd0);
    nxt(); rv(3'b000, 0, 32'h0); #1;
    resp_chk("mix.r1", 1'b1, 32'h00A0_0093, 2'd1);
    nxt(); #1;
    resp_chk("mix.hold", 1'b0, 32'h00A0_0093, 2'd1);

    // Default decode with the DTCM window disabled
    nxt(); region_en = 3'b001; fetch(32'h2000_0004); #1;
    check("dflt.req", 64'(region_req), 64'b100);
    check("dflt.gnt", 64'(fetch_gnt), 64'd1);
    nxt(); fetch_req = 1'b0; region_en = 3'b011; rv(3'b100, 2, 32'hDEAD_BEEF); #1;
    nxt(); rv(3'b000, 2, 32'h0); #1;
    resp_chk("dflt.r", 1'b1, 32'hDEAD_BEEF, 2'd2);

    // Back-pressure on a full FIFO; the pointers wrap
    nxt(); fetch(32'h0000_0010); #1;
    check("bp.gnt0", 64'(fetch_gnt), 64'd1);
    nxt(); fetch(32'h0000_0014); #1;
    check("bp.gnt1", 64'(fetch_gnt), 64'd1);
    nxt(); fetch(32'h0000_0018); #1;
    check("bp.full_gnt", 64'(fetch_gnt), 64'd0);
    check("bp.full_req", 64'(region_req), 64'b000);
    nxt(); rv(3'b001, 0, 32'h0000_0111); #1;
    check("bp.pop_gnt", 64'(fetch_gnt), 64'd0);
    nxt(); rv(3'b000, 0, 32'h0); #1;
    check("bp.after_gnt", 64'(fetch_gnt), 64'd1);
    resp_chk("bp.r0", 1'b1, 32'h0000_0111, 2'd0);
    nxt(); fetch_req = 1'b0; rv(3'b001, 0, 32'h0000_0222); #1;
    nxt(); fetch(32'h2000_0000); rv(3'b000, 0, 32'h0); #1;
    check("bp.gnt3", 64'(fetch_gnt), 64'd1);
    resp_chk("bp.r1", 1'b1, 32'h0000_0222, 2'd0);
    nxt(); fetch_req = 1'b0; rv(3'b001, 0, 32'h0000_0333); #1;
    nxt(); rv(3'b010, 1, 32'h0000_0444); #1;
    resp_chk("bp.r2", 1'b1, 32'h0000_0333, 2'd0);
    nxt(); rv(3'b000, 0, 32'h0); #1;
    resp_chk("bp.r3", 1'b1, 32'h0000_0444, 2'd1);

    // Flush with two fetches in flight
    nxt(); fetch(32'h0000_0010); #1;
    nxt(); fetch(32'h2000_0008); #1;
    nxt(); fetch(32'h0000_0100); flush = 1'b1; #1;
    check("fl.gnt", 64'(fetch_gnt), 64'd0);
    check("fl.req", 64'(region_req), 64'b000);
    nxt(); fetch_req = 1'b0; flush = 1'b0; rv(3'b001, 0, 32'h0000_0555); #1;
    nxt(); rv(3'b010, 1, 32'h0000_0666); #1;
    check("fl.drop0", 64'(instr_read_data_valid), 64'd0);
    nxt(); rv(3'b000, 0, 32'h0); #1;
    resp_chk("fl.drop1", 1'b0, 32'h0000_0444, 2'd1);
    nxt(); fetch(32'h0000_0100); #1;
    check("fl.new_gnt", 64'(fetch_gnt), 64'd1);
    check("fl.new_req", 64'(region_req), 64'b001);
    nxt(); fetch_req = 1'b0; rv(3'b001, 0, 32'h0000_0777); #1;
    nxt(); rv(3'b000, 0, 32'h0); #1;
    resp_chk("fl.new", 1'b1, 32'h0000_0777, 2'd0);
    // Flush coincident with the head response
    nxt(); fetch(32'h0000_0010); #1;
    nxt(); fetch_req = 1'b0; flush = 1'b1; rv(3'b001, 0, 32'h0000_0888); #1;
    nxt(); flush = 1'b0; rv(3'b000, 0, 32'h0); fetch(32'h0000_0020); #1;
    check("flc.drop", 64'(instr_read_data_valid), 64'd0);
    check("flc.gnt", 64'(fetch_gnt), 64'd1);
    nxt(); fetch_req = 1'b0; rv(3'b001, 0, 32'h0000_0999); #1;
    nxt(); rv(3'b000, 0, 32'h0); #1;
    resp_chk("flc.new", 1'b1, 32'h0000_0999, 2'd0);
    check("flc.err", 64'(resp_err), 64'd0);

    // The block suppresses the request and holds the head response
    nxt(); region_block = 3'b001; fetch(32'h0000_0010); #1;
    check("blk.req", 64'(region_req), 64'b000);
    check("blk.gnt", 64'(fetch_gnt), 64'd0);
    nxt(); region_block = 3'b000; #1;
    check("blk.rel_gnt", 64'(fetch_gnt), 64'd1);
    nxt(); fetch_req = 1'b0; region_block = 3'b001; rv(3'b001, 0, 32'h0000_0AAA); #1;
    nxt(); #1;
    check("blk.hold0", 64'(instr_read_data_valid), 64'd0);
    nxt(); region_block = 3'b000; #1;
    check("blk.hold1", 64'(instr_read_data_valid), 64'd0);
    nxt(); rv(3'b000, 0, 32'h0); #1;
    resp_chk("blk.r", 1'b1, 32'h0000_0AAA, 2'd0);
    check("blk.err", 64'(resp_err), 64'd0);

    // Spurious response from a non-head region
    nxt(); fetch(32'h0000_0010); #1;
    nxt(); fetch_req = 1'b0; rv(3'b010, 1, 32'h0000_0BBB); #1;
    nxt(); rv(3'b000, 0, 32'h0); #1;
    check("sp.err", 64'(resp_err), 64'd1);
    check("sp.valid", 64'(instr_read_data_valid), 64'd0);
    nxt(); rv(3'b001, 0, 32'h0000_0CCC); #1;
    nxt(); rv(3'b000, 0, 32'h0); #1;
    resp_chk("sp.head", 1'b1, 32'h0000_0CCC, 2'd0);
    check("sp.sticky", 64'(resp_err), 64'd1);

    // Reset mid-operation with two fetches in flight
    nxt(); fetch(32'h0000_0010); #1;
    nxt(); fetch(32'h2000_0000); #1;
    nxt(); fetch_req = 1'b0; #1;
    cpu_rst = 1'b1; #1;
    resp_chk("rst.async", 1'b0, 32'h0, 2'd0);
    check("rst.err", 64'(resp_err), 64'd0);
    check("rst.gnt", 64'(fetch_gnt), 64'd0);
    check("rst.req", 64'(region_req), 64'd0);
    nxt(); cpu_rst = 1'b0; rv(3'b001, 0, 32'h0000_0DDD); #1;
    nxt(); rv(3'b000, 0, 32'h0); #1;
    check("rst.spur_err", 64'(resp_err), 64'd1);
    resp_chk("rst.spur", 1'b0, 32'h0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
